filter_pipeline_sequencer: RTL

//  Frame-level controller for the grayscale -> 3x3 average -> 3x3 Sobel image pipeline.
//  - Accepts R, G, B planes via valid/ready and issues load addresses for the grayscale RAM.
//  - Scans 3x3 windows for the smoothing stage, then the edge stage, and streams the edge RAM out.
//  - Holds no pixel data: drives addresses and enables only for external RAMs and filter cores.

---
 rtl/filter_pipe_pkg.sv | 26 ++
 rtl/filter_pipeline_sequencer_raster_counter.sv | 45 ++++
 rtl/filter_pipeline_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/filter_pipe_pkg.sv
// Shared types and constants for the filter pipeline sequencer.
package filter_pipe_pkg;

   localparam int RES_X_DEF = 32;
   localparam int RES_Y_DEF = 32;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD    = 4'd1,
      SCAN0   = 4'd2,
      FLUSH0  = 4'd3,
      PAD0    = 4'd4,
      SCAN1   = 4'd5,
      FLUSH1  = 4'd6,
      PAD1    = 4'd7,
      READOUT = 4'd8
   } state_t;

   localparam logic [1:0] PLANE_R = 2'd0;
   localparam logic [1:0] PLANE_G = 2'd1;
   localparam logic [1:0] PLANE_B = 2'd2;

   localparam logic STAGE_SMOOTH = 1'b0;
   localparam logic STAGE_EDGE   = 1'b1;

endpackage

// File: rtl/filter_pipeline_sequencer_raster_counter.sv
// Row/column raster position counter; wraps from (MAX_Y,MAX_X) back to (0,0).
module raster_counter #(
   parameter int MAX_X = 31,
   parameter int MAX_Y = 31,
   parameter int W     = 5
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic         i_clear,
   output logic [W-1:0] o_row,
   output logic [W-1:0] o_col,
   output logic         o_last
);

   logic [W-1:0] r_row;
   logic [W-1:0] r_col;
   logic         w_col_end;
   logic         w_row_end;

   assign w_col_end = (r_col == W'(MAX_X));
   assign w_row_end = (r_row == W'(MAX_Y));
   assign o_row     = r_row;
   assign o_col     = r_col;
   assign o_last    = w_col_end & w_row_end;

   // Advance one raster position per enabled cycle; clear has priority.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_en) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + W'(1);
         end else begin
            r_col <= r_col + W'(1);
         end
      end
   end

endmodule

// File: rtl/filter_pipeline_sequencer.sv
// Frame controller for the gray -> 3x3 average -> 3x3 Sobel pipeline.
// Drives RAM addresses/enables only; no pixel data passes through here.
// Optional feature macro: PAD_WRITE_EN (adds PAD0/PAD1 border-zeroing sweeps).
//
// state   | meaning
// IDLE    | waiting for start_i
// LOAD    | accepting R,G,B planes in raster order
// SCAN0   | issuing smoothing windows, one per cycle
// FLUSH0  | last smoothing write lands, no new window
// PAD0    | zero border cells of the smoothing RAM (PAD_WRITE_EN only)
// SCAN1   | issuing edge windows, one per cycle
// FLUSH1  | last edge write lands, no new window
// PAD1    | zero border cells of the edge RAM (PAD_WRITE_EN only)
// READOUT | streaming edge RAM out under valid/ready
module filter_pipeline_sequencer
   import filter_pipe_pkg::*;
#(
   parameter  int RES_X = RES_X_DEF,
   parameter  int RES_Y = RES_Y_DEF,
   localparam int AW    = $clog2((RES_X > RES_Y) ? RES_X : RES_Y)
) (
   input  logic          clk_i,
   input  logic          reset,
   input  logic          start_i,
   input  logic          pix_valid_i,
   output logic          pix_ready_o,
   output logic          load_en_o,
   output logic [1:0]    plane_o,
   output logic [AW-1:0] load_row_o,
   output logic [AW-1:0] load_col_o,
   output logic          stage_o,
   output logic          win_valid_o,
   output logic [AW-1:0] win_row_o,
   output logic [AW-1:0] win_col_o,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_row_o,
   output logic [AW-1:0] wr_col_o,
   output logic          pad_en_o,
   output logic [AW-1:0] pad_row_o,
   output logic [AW-1:0] pad_col_o,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [AW-1:0] out_row_o,
   output logic [AW-1:0] out_col_o,
   output logic          busy_o,
   output logic          frame_done_o
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_plane;
   logic          r_wr_en;
   logic [AW-1:0] r_wr_row;
   logic [AW-1:0] r_wr_col;

   logic          w_pix_ready;
   logic          w_load_en;
   logic          w_win_valid;
   logic          w_pad_en;
   logic          w_out_valid;
   logic          w_out_acc;
   logic          w_stage;
   logic          w_frame_done;
   logic          w_idle;
   logic          w_load_last;
   logic          w_win_last;
   logic          w_out_last;
   logic          w_pad_last;
   logic [AW-1:0] w_win_row;
   logic [AW-1:0] w_win_col;
   logic [AW-1:0] w_pad_row;
   logic [AW-1:0] w_pad_col;

   assign w_idle    = (r_state == IDLE);
   assign w_load_en = pix_valid_i & w_pix_ready;
   assign w_out_acc = w_out_valid & out_ready_i;

   raster_counter #(.MAX_X(RES_X-1), .MAX_Y(RES_Y-1), .W(AW)) u_load_pos (
      .i_clk(clk_i), .i_rst_n(reset), .i_en(w_load_en), .i_clear(w_idle),
      .o_row(load_row_o), .o_col(load_col_o), .o_last(w_load_last)
   );

   raster_counter #(.MAX_X(RES_X-3), .MAX_Y(RES_Y-3), .W(AW)) u_win_pos (
      .i_clk(clk_i), .i_rst_n(reset), .i_en(w_win_valid), .i_clear(w_idle),
      .o_row(w_win_row), .o_col(w_win_col), .o_last(w_win_last)
   );

   raster_counter #(.MAX_X(RES_X-1), .MAX_Y(RES_Y-1), .W(AW)) u_out_pos (
      .i_clk(clk_i), .i_rst_n(reset), .i_en(w_out_acc), .i_clear(w_idle),
      .o_row(out_row_o), .o_col(out_col_o), .o_last(w_out_last)
   );

`ifdef PAD_WRITE_EN
   logic [AW-1:0] r_pad_row;
   logic [AW-1:0] r_pad_col;

   assign w_pad_row  = r_pad_row;
   assign w_pad_col  = r_pad_col;
   assign w_pad_last = (r_pad_row == AW'(RES_Y-1)) && (r_pad_col == AW'(RES_X-1));

   // Border-only raster sweep: full rows at top/bottom, jump 0 -> RES_X-1 on interior rows.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_pad_row <= '0;
         r_pad_col <= '0;
      end else if (w_pad_en) begin
         if (w_pad_last) begin
            r_pad_row <= '0;
            r_pad_col <= '0;
         end else if (r_pad_col == AW'(RES_X-1)) begin
            r_pad_col <= '0;
            r_pad_row <= r_pad_row + AW'(1);
         end else if ((r_pad_row == '0) || (r_pad_row == AW'(RES_Y-1))) begin
            r_pad_col <= r_pad_col + AW'(1);
         end else begin
            r_pad_col <= AW'(RES_X-1);
         end
      end
   end
`else
   assign w_pad_row  = '0;
   assign w_pad_col  = '0;
   assign w_pad_last = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode and per-state enables.
   always_comb begin
      w_state_nxt  = r_state;
      w_pix_ready  = 1'b0;
      w_win_valid  = 1'b0;
      w_pad_en     = 1'b0;
      w_out_valid  = 1'b0;
      w_stage      = STAGE_SMOOTH;
      w_frame_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) w_state_nxt = LOAD;
         end
         LOAD: begin
            w_pix_ready = 1'b1;
            if (pix_valid_i && w_load_last && (r_plane == PLANE_B)) w_state_nxt = SCAN0;
         end
         SCAN0: begin
            w_win_valid = 1'b1;
            if (w_win_last) w_state_nxt = FLUSH0;
         end
         FLUSH0: begin
`ifdef PAD_WRITE_EN
            w_state_nxt = PAD0;
`else
            w_state_nxt = SCAN1;
`endif
         end
`ifdef PAD_WRITE_EN
         PAD0: begin
            w_pad_en = 1'b1;
            if (w_pad_last) w_state_nxt = SCAN1;
         end
`endif
         SCAN1: begin
            w_stage     = STAGE_EDGE;
            w_win_valid = 1'b1;
            if (w_win_last) w_state_nxt = FLUSH1;
         end
         FLUSH1: begin
            w_stage = STAGE_EDGE;
`ifdef PAD_WRITE_EN
            w_state_nxt = PAD1;
`else
            w_state_nxt = READOUT;
`endif
         end
`ifdef PAD_WRITE_EN
         PAD1: begin
            w_stage  = STAGE_EDGE;
            w_pad_en = 1'b1;
            if (w_pad_last) w_state_nxt = READOUT;
         end
`endif
         READOUT: begin
            w_stage     = STAGE_EDGE;
            w_out_valid = 1'b1;
            if (out_ready_i && w_out_last) begin
               w_frame_done = 1'b1;
               w_state_nxt  = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Plane index steps R -> G -> B on each full-frame wrap of the load position.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_plane <= PLANE_R;
      end else if (w_idle) begin
         r_plane <= PLANE_R;
      end else if (w_load_en && w_load_last) begin
         r_plane <= (r_plane == PLANE_B) ? PLANE_R : r_plane + 2'd1;
      end
   end

   // Filter result write trails the window issue by one cycle, centred on the window.
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_wr_en  <= 1'b0;
         r_wr_row <= '0;
         r_wr_col <= '0;
      end else begin
         r_wr_en  <= w_win_valid;
         r_wr_row <= w_win_row + AW'(1);
         r_wr_col <= w_win_col + AW'(1);
      end
   end

   assign pix_ready_o  = w_pix_ready;
   assign load_en_o    = w_load_en;
   assign plane_o      = r_plane;
   assign stage_o      = w_stage;
   assign win_valid_o  = w_win_valid;
   assign win_row_o    = w_win_row;
   assign win_col_o    = w_win_col;
   assign wr_en_o      = r_wr_en;
   assign wr_row_o     = r_wr_row;
   assign wr_col_o     = r_wr_col;
   assign pad_en_o     = w_pad_en;
   assign pad_row_o    = w_pad_row;
   assign pad_col_o    = w_pad_col;
   assign out_valid_o  = w_out_valid;
   assign busy_o       = ~w_idle;
   assign frame_done_o = w_frame_done;

endmodule
